// File: rtl/ysyx_220578_mem_arbiter_pkg.sv
// rtl/ysyx_220578_mem_arbiter_pkg.sv - shared encodings and default widths for the memory arbiter
package ysyx_220578_mem_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH   = 64;
  localparam int DEF_DATA_WIDTH   = 64;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_TIMEOUT      = 255;
  localparam int TMO_WIDTH        = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

endpackage

// File: rtl/ysyx_220578_mem_arbiter_if.sv
// rtl/ysyx_220578_mem_arbiter_if.sv - IFU, LSU and memory-side signals of the arbiter
interface ysyx_220578_mem_arbiter_if
  import ysyx_220578_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                    ifu_req_valid;
  logic                    ifu_req_ready;
  logic [ADDR_WIDTH-1:0]   ifu_addr;
  logic                    ifu_resp_valid;
  logic [DATA_WIDTH-1:0]   ifu_resp_data;
  logic                    lsu_req_valid;
  logic                    lsu_req_ready;
  logic [ADDR_WIDTH-1:0]   lsu_addr;
  logic                    lsu_wen;
  logic [DATA_WIDTH-1:0]   lsu_wdata;
  logic [DATA_WIDTH/8-1:0] lsu_wmask;
  logic                    lsu_resp_valid;
  logic [DATA_WIDTH-1:0]   lsu_resp_data;
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic                    mem_wen;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_wmask;
  logic                    mem_resp_valid;
  logic [DATA_WIDTH-1:0]   mem_resp_data;
  logic                    bus_err;

  // master is the arbiter itself; slave is the requesters plus memory around it
  modport master (
    input  ifu_req_valid, ifu_addr, lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
           mem_req_ready, mem_resp_valid, mem_resp_data,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_data, lsu_req_ready, lsu_resp_valid,
           lsu_resp_data, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, bus_err
  );

  modport slave (
    output ifu_req_valid, ifu_addr, lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
           mem_req_ready, mem_resp_valid, mem_resp_data,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_data, lsu_req_ready, lsu_resp_valid,
           lsu_resp_data, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, bus_err
  );

endinterface

// File: rtl/ysyx_220578_mem_arbiter_arb_pick.sv
// rtl/ysyx_220578_mem_arbiter_arb_pick.sv - combinational LSU-first picker with IFU starvation override
module ysyx_220578_arb_pick
  import ysyx_220578_mem_arbiter_pkg::*;
(
  input  logic   idle,
  input  logic   ifu_valid,
  input  logic   lsu_valid,
  input  logic   starved,
  output logic   ifu_ready,
  output logic   lsu_ready,
  output logic   grant,
  output owner_t grant_owner
);

  always_comb begin
    lsu_ready   = idle && !(ifu_valid && starved);
    ifu_ready   = idle && (!lsu_valid || starved);
    grant       = (lsu_valid && lsu_ready) || (ifu_valid && ifu_ready);
    grant_owner = (lsu_valid && lsu_ready) ? OWN_LSU : OWN_IFU;
  end

endmodule

// File: rtl/ysyx_220578_mem_arbiter.sv
// rtl/ysyx_220578_mem_arbiter.sv - single-port memory arbiter between IFU and LSU with timeout guard
module ysyx_220578_mem_arbiter
  import ysyx_220578_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input logic clk,
  input logic rst,
  ysyx_220578_mem_arbiter_if.master bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]        STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TMO_WIDTH-1:0] TMO_LAST   = TMO_WIDTH'(TIMEOUT - 1);

  state_t                  state, state_next;
  owner_t                  owner, grant_owner;
  logic [SW-1:0]           starve_cnt;
  logic [TMO_WIDTH-1:0]    tmo_cnt;
  logic                    idle, grant, ifu_ready, lsu_ready, resp_hit, tmo_hit;
  logic [ADDR_WIDTH-1:0]   addr_sel;
  logic [DATA_WIDTH-1:0]   wdata_sel;
  logic [DATA_WIDTH/8-1:0] wmask_sel;
  logic                    wen_sel;

  // readies are held low while reset is asserted so nothing is accepted into a reset cycle
  assign idle = (state == ST_IDLE) && !rst;

  ysyx_220578_arb_pick pick (
    .idle        (idle),
    .ifu_valid   (bus.ifu_req_valid),
    .lsu_valid   (bus.lsu_req_valid),
    .starved     (starve_cnt == STARVE_MAX),
    .ifu_ready   (ifu_ready),
    .lsu_ready   (lsu_ready),
    .grant       (grant),
    .grant_owner (grant_owner)
  );

  assign bus.ifu_req_ready = ifu_ready;
  assign bus.lsu_req_ready = lsu_ready;

  // timeout fires on the TIMEOUT-th silent WAIT cycle, so WAIT never lasts longer than TIMEOUT
  assign resp_hit = (state == ST_WAIT) && bus.mem_resp_valid;
  assign tmo_hit  = (state == ST_WAIT) && !bus.mem_resp_valid && (tmo_cnt == TMO_LAST);

  always_comb begin
    addr_sel  = bus.ifu_addr;
    wen_sel   = 1'b0;
    wdata_sel = '0;
    wmask_sel = '0;
    if (grant_owner == OWN_LSU) begin
      addr_sel  = bus.lsu_addr;
      wen_sel   = bus.lsu_wen;
      wdata_sel = bus.lsu_wdata;
      wmask_sel = bus.lsu_wmask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (grant) state_next = ST_REQ;
      ST_REQ:  if (bus.mem_req_ready) state_next = ST_WAIT;
      ST_WAIT: if (resp_hit || tmo_hit) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner              <= OWN_IFU;
      starve_cnt         <= '0;
      tmo_cnt            <= '0;
      bus.mem_req_valid  <= 1'b0;
      bus.mem_addr       <= '0;
      bus.mem_wen        <= 1'b0;
      bus.mem_wdata      <= '0;
      bus.mem_wmask      <= '0;
      bus.ifu_resp_valid <= 1'b0;
      bus.ifu_resp_data  <= '0;
      bus.lsu_resp_valid <= 1'b0;
      bus.lsu_resp_data  <= '0;
      bus.bus_err        <= 1'b0;
    end else begin
      bus.ifu_resp_valid <= 1'b0;
      bus.lsu_resp_valid <= 1'b0;
      bus.bus_err        <= 1'b0;
      if (grant) begin
        owner             <= grant_owner;
        bus.mem_req_valid <= 1'b1;
        bus.mem_addr      <= addr_sel;
        bus.mem_wen       <= wen_sel;
        bus.mem_wdata     <= wdata_sel;
        bus.mem_wmask     <= wmask_sel;
        if (grant_owner == OWN_IFU)
          starve_cnt <= '0;
        else if (bus.ifu_req_valid && starve_cnt != STARVE_MAX)
          starve_cnt <= starve_cnt + 1'b1;
      end
      if (state == ST_REQ && bus.mem_req_ready) begin
        bus.mem_req_valid <= 1'b0;
        tmo_cnt           <= '0;
      end
      if (resp_hit || tmo_hit) begin
        bus.bus_err <= tmo_hit;
        if (owner == OWN_LSU) begin
          bus.lsu_resp_valid <= 1'b1;
          bus.lsu_resp_data  <= (tmo_hit || bus.mem_wen) ? DATA_WIDTH'(0) : bus.mem_resp_data;
        end else begin
          bus.ifu_resp_valid <= 1'b1;
          bus.ifu_resp_data  <= tmo_hit ? DATA_WIDTH'(0) : bus.mem_resp_data;
        end
      end else if (state == ST_WAIT) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

endmodule
